rggen_adapter_core: RTL and testbench
=====================================

// Module: rggen_adapter_core
// PURPOSE
//  Bus-protocol-independent core between a protocol bridge (rggen_bus_if) and N registers (rggen_register_if).
//  Issues a one-cycle register request per bus transaction and checks the address window.
//  Selects the responding register's status/read data, with an optional registered response slice.
//  Optionally aborts transactions that never complete.
// PARAMETERS
//  ADDRESS_WIDTH      8   bus address width
//  BUS_WIDTH          32  data width; strobe width = BUS_WIDTH/8
//  REGISTERS          1   number of register_if ports (>=1)
//  BASE_ADDRESS       '0  byte address of window start (ADDRESS_WIDTH bits)
//  BYTE_SIZE          256 window size in bytes; in-window = BASE_ADDRESS <= addr < BASE_ADDRESS+BYTE_SIZE
//  ERROR_STATUS       0   1: unmapped/out-of-window access returns RGGEN_SLAVE_ERROR, else RGGEN_OKAY
//  DEFAULT_READ_DATA  '0  read data returned for unmapped/out-of-window/timed-out access
//  INSERT_SLICER      0   1: register the response, +1 cycle latency
//  TIMEOUT_CYCLES     256 watchdog limit (used only with RGGEN_ADAPTER_TIMEOUT_EN), >=2
// PORTS
//  i_clk        input   1  clock
//  i_rst_n      input   1  asynchronous, active-low reset
//  bus_if       slave   -  valid/address/write/write_data/strobe in; ready/status/read_data out
//  register_if  host    [REGISTERS]  valid/address/write/write_data/strobe out; ready/active/status/read_data in
// BEHAVIOUR
//  FSM states:
//   IDLE -> BUSY     on bus_if.valid
//   BUSY -> IDLE     on completion (INSERT_SLICER=0)
//   BUSY -> RESPOND  on completion (INSERT_SLICER=1)
//   RESPOND -> IDLE  after 1 cycle
//   A request that completes in its first cycle goes IDLE -> IDLE (slicer=0) or IDLE -> RESPOND (slicer=1).
//  Request:
//   register_if[*].valid = bus_if.valid & state==IDLE & in_window; high for exactly one cycle per transaction.
//   address/write/write_data/strobe pass through combinationally to all registers.
//   Out-of-window access: no register valid; completes in the issue cycle with default response (ERROR_STATUS/DEFAULT_READ_DATA).
//  Completion:
//   any register ready while in IDLE-issue or BUSY, or default hit = (no register active).
//   Multiple readies: lowest index wins (status, read_data and ready from same index).
//  Response:
//   INSERT_SLICER=0: bus_if.ready/status/read_data combinational in the completion cycle.
//   INSERT_SLICER=1: captured at completion; bus_if.ready high exactly the next cycle (RESPOND) with the captured values.
//   Register readies seen in IDLE-without-valid or RESPOND are ignored.
//  Reset values (async, immediate):
//   state=IDLE; bus_if.ready=0; status=RGGEN_OKAY; read_data=0; register_if[*].valid=0; timeout counter=0.
//   Reset mid-transaction abandons the transaction; no response is produced.
//  Bridge contract: valid/address/write/write_data held until bus_if.ready; violation behaviour undefined.
// CONFIGURATION
//  RGGEN_ADAPTER_TIMEOUT_EN defined:
//   counter clears on entry to BUSY, increments each BUSY cycle.
//   On reaching TIMEOUT_CYCLES-1 without completion: respond RGGEN_SLAVE_ERROR + DEFAULT_READ_DATA (via slicer if enabled).
//   Completion in the same cycle as expiry: register response wins.
//  Not defined: no counter; BUSY waits indefinitely; TIMEOUT_CYCLES ignored.
// TESTING
//  Write 0x12345678 to in-window reg1, ready same cycle, slicer=0 -> reg1 valid 1 cycle; bus ready same cycle; status OKAY.
//  Read reg0 (data 0xCAFEF00D, ready 3 cycles after valid), slicer=1 -> bus ready 4 cycles after valid; read_data 0xCAFEF00D; reg valid only in cycle 0.
//  Read BASE_ADDRESS+BYTE_SIZE, ERROR_STATUS=1, DEFAULT_READ_DATA=0xDEADBEEF -> no register valid; SLAVE_ERROR, 0xDEADBEEF in issue cycle.
//  In-window unmapped (no active), ERROR_STATUS=0 -> OKAY, default data, ready in issue cycle.
//  TIMEOUT_EN, TIMEOUT_CYCLES=8, register never ready -> ready with SLAVE_ERROR 8 cycles after valid; next request issues normally.
//  Assert i_rst_n=0 while BUSY -> ready/valid drop immediately; after release, new write completes OKAY.

Source files
------------

// File: rtl/rggen_adapter_core.sv
// Protocol-independent core between a bus bridge and REGISTERS register ports.
// Optional watchdog: define RGGEN_ADAPTER_TIMEOUT_EN.
module rggen_adapter_core #(
    parameter int unsigned            ADDRESS_WIDTH     = 8,
    parameter int unsigned            BUS_WIDTH         = 32,
    parameter int unsigned            REGISTERS         = 1,
    parameter bit [ADDRESS_WIDTH-1:0] BASE_ADDRESS      = '0,
    parameter int unsigned            BYTE_SIZE         = 256,
    parameter bit                     ERROR_STATUS      = 1'b0,
    parameter bit [BUS_WIDTH-1:0]     DEFAULT_READ_DATA = '0,
    parameter bit                     INSERT_SLICER     = 1'b0,
    parameter int unsigned            TIMEOUT_CYCLES    = 256
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           bus_valid,
    input  logic [ADDRESS_WIDTH-1:0]       bus_address,
    input  logic                           bus_write,
    input  logic [BUS_WIDTH-1:0]           bus_write_data,
    input  logic [BUS_WIDTH/8-1:0]         bus_strobe,
    output logic                           bus_ready,
    output logic [1:0]                     bus_status,
    output logic [BUS_WIDTH-1:0]           bus_read_data,
    output logic [REGISTERS-1:0]           register_valid,
    output logic [ADDRESS_WIDTH-1:0]       register_address,
    output logic                           register_write,
    output logic [BUS_WIDTH-1:0]           register_write_data,
    output logic [BUS_WIDTH/8-1:0]         register_strobe,
    input  logic [REGISTERS-1:0]           register_ready,
    input  logic [REGISTERS-1:0]           register_active,
    input  logic [2*REGISTERS-1:0]         register_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0] register_read_data
);

    localparam logic [1:0] RGGEN_OKAY        = 2'b00;
    localparam logic [1:0] RGGEN_SLAVE_ERROR = 2'b10;
    // Wide enough that base+size never wraps and addr-base underflows out of range.
    localparam int unsigned EXT_WIDTH = ADDRESS_WIDTH + 33;

    typedef enum logic [1:0] {StIdle, StBusy, StRespond} state_e;

    state_e                 state_q;
    state_e                 state_d;
    logic [EXT_WIDTH-1:0]   offset;
    logic                   in_window;
    logic                   issue;
    logic                   accepting;
    logic                   sel_ready;
    logic [1:0]             sel_status;
    logic [BUS_WIDTH-1:0]   sel_data;
    logic                   reg_hit;
    logic                   default_hit;
    logic                   timeout_hit;
    logic                   complete;
    logic [1:0]             resp_status;
    logic [BUS_WIDTH-1:0]   resp_data;

    assign offset    = EXT_WIDTH'(bus_address) - EXT_WIDTH'(BASE_ADDRESS);
    assign in_window = offset < EXT_WIDTH'(BYTE_SIZE);

    assign issue     = bus_valid && (state_q == StIdle);
    assign accepting = issue || (state_q == StBusy);

    assign register_valid      = {REGISTERS{issue && in_window}};
    assign register_address    = bus_address;
    assign register_write      = bus_write;
    assign register_write_data = bus_write_data;
    assign register_strobe     = bus_strobe;

    // Descending scan so the lowest-index ready register wins.
    always_comb begin
        sel_ready  = 1'b0;
        sel_status = RGGEN_OKAY;
        sel_data   = '0;
        for (int i = int'(REGISTERS) - 1; i >= 0; i--) begin
            if (register_ready[i]) begin
                sel_ready  = 1'b1;
                sel_status = register_status[2*i+:2];
                sel_data   = register_read_data[BUS_WIDTH*i+:BUS_WIDTH];
            end
        end
    end

    assign reg_hit     = sel_ready && in_window;
    assign default_hit = !in_window || !(|register_active);
    assign complete    = accepting && (reg_hit || default_hit || timeout_hit);

    always_comb begin
        resp_status = RGGEN_SLAVE_ERROR;
        resp_data   = DEFAULT_READ_DATA;
        if (reg_hit) begin
            resp_status = sel_status;
            resp_data   = sel_data;
        end else if (default_hit) begin
            resp_status = ERROR_STATUS ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus_valid && complete) begin
                    if (INSERT_SLICER) state_d = StRespond;
                end else if (bus_valid) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (complete) state_d = INSERT_SLICER ? StRespond : StIdle;
            end
            StRespond: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef RGGEN_ADAPTER_TIMEOUT_EN
    localparam int unsigned COUNT_WIDTH = $clog2(TIMEOUT_CYCLES);

    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;

    // Held at zero outside BUSY, so it starts from zero on every entry.
    assign count_d     = (state_q == StBusy) ? count_q + 1'b1 : '0;
    assign timeout_hit = (state_q == StBusy) && (count_q == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
`else
    // Without the watchdog BUSY waits indefinitely.
    assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES == 0);
`endif

    if (INSERT_SLICER) begin : g_slicer
        logic [1:0]           status_q;
        logic [BUS_WIDTH-1:0] data_q;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                status_q <= RGGEN_OKAY;
                data_q   <= '0;
            end else if (complete) begin
                status_q <= resp_status;
                data_q   <= resp_data;
            end
        end

        assign bus_ready     = (state_q == StRespond);
        assign bus_status    = status_q;
        assign bus_read_data = data_q;
    end else begin : g_no_slicer
        assign bus_ready     = complete;
        assign bus_status    = complete ? resp_status : RGGEN_OKAY;
        assign bus_read_data = complete ? resp_data : '0;
    end

endmodule

// File: tb/tb_rggen_adapter_core.sv
// Bench for rggen_adapter_core: two instances (no slicer / slicer) driven from a vector table.
module tb_rggen_adapter_core;

    localparam int NDUT = 2;
    localparam int NREG = 3;
    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ERR = 2'b10;
    localparam logic [2*NREG-1:0]  REG_STATUS = {ERR, OK, OK};
    localparam logic [32*NREG-1:0] REG_DATA   = {32'h22222222, 32'h11111111, 32'hCAFEF00D};

    typedef struct {
        int          dut;
        logic [7:0]  addr;
        bit          write;
        logic [31:0] wdata;
        int          lat;
        int          force_cyc;
        logic [2:0]  force_mask;
        logic [1:0]  exp_status;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_valid;
    } vec_t;

    typedef struct {
        logic [1:0]  status;
        logic [31:0] data;
        int          lat;
        int          valid;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            bus_valid   [NDUT];
    logic [7:0]      bus_address [NDUT];
    logic            bus_write   [NDUT];
    logic [31:0]     bus_wdata   [NDUT];
    logic [3:0]      bus_strobe  [NDUT];
    logic            bus_ready   [NDUT];
    logic [1:0]      bus_status  [NDUT];
    logic [31:0]     bus_rdata   [NDUT];
    logic [NREG-1:0] reg_valid   [NDUT];
    logic [31:0]     reg_wdata   [NDUT];
    int              reg_lat     [NDUT];
    logic [NREG-1:0] force_ready [NDUT];

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    vec_t vecs[$];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic [NREG-1:0] valid_l;
        logic [NREG-1:0] ready_l;
        logic [NREG-1:0] active_l;
        logic [7:0]      addr_l;
        logic            write_l;
        logic [31:0]     wdata_l;
        logic [3:0]      strobe_l;
        logic            ready_o;
        logic [1:0]      status_o;
        logic [31:0]     rdata_o;
        int              cnt;
        logic            pend;

        rggen_adapter_core #(
            .ADDRESS_WIDTH     (8),
            .BUS_WIDTH         (32),
            .REGISTERS         (NREG),
            .BASE_ADDRESS      (8'h40),
            .BYTE_SIZE         (32),
            .ERROR_STATUS      (g == 0),
            .DEFAULT_READ_DATA (g == 0 ? 32'hDEADBEEF : 32'h0BADC0DE),
            .INSERT_SLICER     (g == 1),
            .TIMEOUT_CYCLES    (8)
        ) u_dut (
            .i_clk               (clk),
            .i_rst_n             (rst_n),
            .bus_valid           (bus_valid[g]),
            .bus_address         (bus_address[g]),
            .bus_write           (bus_write[g]),
            .bus_write_data      (bus_wdata[g]),
            .bus_strobe          (bus_strobe[g]),
            .bus_ready           (ready_o),
            .bus_status          (status_o),
            .bus_read_data       (rdata_o),
            .register_valid      (valid_l),
            .register_address    (addr_l),
            .register_write      (write_l),
            .register_write_data (wdata_l),
            .register_strobe     (strobe_l),
            .register_ready      (ready_l),
            .register_active     (active_l),
            .register_status     (REG_STATUS),
            .register_read_data  (REG_DATA)
        );

        assign bus_ready[g]  = ready_o;
        assign bus_status[g] = status_o;
        assign bus_rdata[g]  = rdata_o;
        assign reg_valid[g]  = valid_l;
        assign reg_wdata[g]  = wdata_l;

        // Register k lives at 0x40+4k and answers reg_lat cycles after its valid.
        always_comb begin
            active_l = '0;
            ready_l  = '0;
            for (int k = 0; k < NREG; k++) begin
                active_l[k] = (addr_l == 8'(64 + 4 * k));
                ready_l[k]  = force_ready[g][k] | (active_l[k] &
                              ((valid_l[k] & (reg_lat[g] == 0)) | (pend & (cnt == reg_lat[g]))));
            end
        end

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pend <= 1'b0;
                cnt  <= 0;
            end else if (|valid_l) begin
                pend <= (reg_lat[g] > 0);
                cnt  <= 1;
            end else if (pend) begin
                if (cnt == reg_lat[g]) pend <= 1'b0;
                else cnt <= cnt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        int   cyc;
        int   vcount;
        bit   done;
        int   d;
        d = v.dut;
        reg_lat[d] = v.lat;
        @(negedge clk);
        bus_valid[d]   = 1'b1;
        bus_address[d] = v.addr;
        bus_write[d]   = v.write;
        bus_wdata[d]   = v.wdata;
        bus_strobe[d]  = 4'hF;
        sb.push_back('{v.exp_status, v.exp_data, v.exp_lat, v.exp_valid});
        cyc = 0;
        vcount = 0;
        done = 1'b0;
        while (!done && cyc <= 40) begin
            force_ready[d] = (cyc == v.force_cyc) ? v.force_mask : '0;
            #1;
            if (|reg_valid[d]) vcount++;
            if (cyc == 0 && v.write && v.exp_valid != 0)
                check($sformatf("v%0d wdata_pass", idx), reg_wdata[d], v.wdata);
            if (bus_ready[d]) begin
                done = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        e = sb.pop_front();
        if (!done) begin
            check($sformatf("v%0d ready_timeout", idx), 32'(cyc), 32'(e.lat));
        end else begin
            check($sformatf("v%0d status", idx), 32'(bus_status[d]), 32'(e.status));
            check($sformatf("v%0d read_data", idx), bus_rdata[d], e.data);
            check($sformatf("v%0d latency", idx), 32'(cyc), 32'(e.lat));
        end
        @(posedge clk);
        #1;
        bus_valid[d]   = 1'b0;
        force_ready[d] = '0;
        check($sformatf("v%0d reg_valid_cycles", idx), 32'(vcount), 32'(e.valid));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            bus_valid[d]   = 1'b0;
            bus_address[d] = '0;
            bus_write[d]   = 1'b0;
            bus_wdata[d]   = '0;
            bus_strobe[d]  = '0;
            reg_lat[d]     = 0;
            force_ready[d] = '0;
        end
        rst_n = 1'b0;
        #12;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("d%0d reset ready", d), 32'(bus_ready[d]), 32'd0);
            check($sformatf("d%0d reset status", d), 32'(bus_status[d]), 32'(OK));
            check($sformatf("d%0d reset read_data", d), bus_rdata[d], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Readies while idle with no request must not produce a response.
        @(negedge clk);
        force_ready[0] = 3'b111;
        force_ready[1] = 3'b111;
        #1;
        check("idle_ready d0", 32'(bus_ready[0]), 32'd0);
        check("idle_ready d1", 32'(bus_ready[1]), 32'd0);
        @(negedge clk);
        force_ready[0] = '0;
        force_ready[1] = '0;
        #1;
        check("idle_ready_next d0", 32'(bus_ready[0]), 32'd0);
        check("idle_ready_next d1", 32'(bus_ready[1]), 32'd0);

        // dut addr wr wdata lat fcyc fmask | status data lat valid
        vecs.push_back('{0, 8'h44, 1'b1, 32'h12345678, 0, -1, 3'b000, OK, 32'h11111111, 0, 1});
        vecs.push_back('{1, 8'h40, 1'b0, 32'h0, 3, -1, 3'b000, OK, 32'hCAFEF00D, 4, 1});
        vecs.push_back('{0, 8'h60, 1'b0, 32'h0, 0, -1, 3'b000, ERR, 32'hDEADBEEF, 0, 0});
        vecs.push_back('{1, 8'h4C, 1'b0, 32'h0, 0, -1, 3'b000, OK, 32'h0BADC0DE, 1, 1});
        vecs.push_back('{0, 8'h5F, 1'b0, 32'h0, 0, -1, 3'b000, ERR, 32'hDEADBEEF, 0, 1});
        vecs.push_back('{1, 8'h3F, 1'b0, 32'h0, 0, -1, 3'b000, OK, 32'h0BADC0DE, 1, 0});
        vecs.push_back('{0, 8'h48, 1'b0, 32'h0, 2, -1, 3'b000, ERR, 32'h22222222, 2, 1});
        vecs.push_back('{1, 8'h44, 1'b1, 32'hAABBCCDD, 0, -1, 3'b000, OK, 32'h11111111, 1, 1});
        vecs.push_back('{0, 8'h48, 1'b0, 32'h0, 1000, 2, 3'b110, OK, 32'h11111111, 2, 1});
        vecs.push_back('{1, 8'h48, 1'b0, 32'h0, 1000, 1, 3'b011, OK, 32'hCAFEF00D, 2, 1});
        vecs.push_back('{0, 8'h40, 1'b0, 32'h0, 8, -1, 3'b000, OK, 32'hCAFEF00D, 8, 1});
        vecs.push_back('{1, 8'h40, 1'b0, 32'h0, 8, -1, 3'b000, OK, 32'hCAFEF00D, 9, 1});
`ifdef RGGEN_ADAPTER_TIMEOUT_EN
        vecs.push_back('{0, 8'h40, 1'b0, 32'h0, 1000, -1, 3'b000, ERR, 32'hDEADBEEF, 8, 1});
        vecs.push_back('{1, 8'h40, 1'b0, 32'h0, 1000, -1, 3'b000, ERR, 32'h0BADC0DE, 9, 1});
`else
        vecs.push_back('{0, 8'h40, 1'b0, 32'h0, 20, -1, 3'b000, OK, 32'hCAFEF00D, 20, 1});
        vecs.push_back('{1, 8'h40, 1'b0, 32'h0, 20, -1, 3'b000, OK, 32'hCAFEF00D, 21, 1});
`endif
        vecs.push_back('{0, 8'h44, 1'b1, 32'h0F0F0F0F, 1, -1, 3'b000, OK, 32'h11111111, 1, 1});

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Reset while the sliced instance is presenting its response.
        reg_lat[1] = 2;
        @(negedge clk);
        bus_valid[1]   = 1'b1;
        bus_address[1] = 8'h40;
        bus_write[1]   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("pre_reset ready", 32'(bus_ready[1]), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("in_reset ready", 32'(bus_ready[1]), 32'd0);
        check("in_reset status", 32'(bus_status[1]), 32'(OK));
        check("in_reset read_data", bus_rdata[1], 32'd0);
        bus_valid[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_reset no_response", 32'(bus_ready[1]), 32'd0);
        run_vec(100, '{1, 8'h44, 1'b1, 32'h55AA55AA, 0, -1, 3'b000, OK, 32'h11111111, 1, 1});
        run_vec(101, '{0, 8'h40, 1'b1, 32'h00C0FFEE, 0, -1, 3'b000, OK, 32'hCAFEF00D, 0, 1});

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
